// File: rtl/wb_commit_if.sv
// Writeback commit bus: result inputs from MEM, hazard query, and the
// register-file write port. The commit unit sits on the slave side.
interface wb_commit_if #(
   parameter int DATA_W = 64
);
   logic              alu_valid;
   logic [4:0]        alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              ld_valid;
   logic [4:0]        ld_rd;
   logic [DATA_W-1:0] ld_data;
   logic [1:0]        ld_size;
   logic              ld_unsigned;
   logic              in_ready;
   logic [4:0]        q_rs1;
   logic [4:0]        q_rs2;
   logic              pend1;
   logic              pend2;
   logic              regwr;
   logic [5:0]        wr_reg;
   logic [DATA_W-1:0] write_data;

   // Upstream pipeline / hazard logic / register file side
   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_valid, ld_rd, ld_data, ld_size, ld_unsigned,
      output q_rs1, q_rs2,
      input  in_ready, pend1, pend2,
      input  regwr, wr_reg, write_data
   );

   // Commit unit side
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_valid, ld_rd, ld_data, ld_size, ld_unsigned,
      input  q_rs1, q_rs2,
      output in_ready, pend1, pend2,
      output regwr, wr_reg, write_data
   );
endinterface

// File: rtl/wb_commit.sv
// Writeback commit unit: formats load data, serialises load/ALU results in
// program order through a small FIFO (with empty-FIFO bypass), drives one
// register write per cycle and reports pending destination registers.
module wb_commit #(
   parameter int DATA_W = 64,
   parameter int DEPTH  = 4
) (
   input logic        clk,
   input logic        rst_n,
   wb_commit_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   // Sign- or zero-extend the right-aligned load value to full width
   function automatic logic [DATA_W-1:0] ld_format(
      input logic [DATA_W-1:0] raw,
      input logic [1:0]        size,
      input logic              uns
   );
      logic [DATA_W-1:0] res;
      logic              ext;
      res = raw;
      ext = 1'b0;
      case (size)
         2'b00: begin
            ext = ~uns & raw[7];
            res = {{(DATA_W-8){ext}}, raw[7:0]};
         end
         2'b01: begin
            ext = ~uns & raw[15];
            res = {{(DATA_W-16){ext}}, raw[15:0]};
         end
         2'b10: begin
            ext = ~uns & raw[31];
            res = {{(DATA_W-32){ext}}, raw[31:0]};
         end
         default: res = raw;
      endcase
      return res;
   endfunction

   // FIFO storage and state
   logic [4:0]        rd_mem   [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next, wr_ptr_p1;
   logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]  count_reg, count_next;

   // Output registers feeding the register file directly
   logic              regwr_reg;
   logic [5:0]        wr_reg_reg;
   logic [DATA_W-1:0] write_data_reg;

   // Acceptance and the (up to two) newly arriving entries, oldest first
   logic              in_ready;
   logic              ld_take, alu_take;
   logic [DATA_W-1:0] ld_fmt;
   logic              new0_valid, new1_valid;
   logic [4:0]        new0_rd, new1_rd;
   logic [DATA_W-1:0] new0_data, new1_data;
   logic              fifo_empty;

   // Commit selection and enqueue slots
   logic              deq;
   logic              commit_valid;
   logic [4:0]        commit_rd;
   logic [DATA_W-1:0] commit_data;
   logic              enq0_valid, enq1_valid;
   logic [4:0]        enq0_rd, enq1_rd;
   logic [DATA_W-1:0] enq0_data, enq1_data;

   // Hazard tracking per FIFO slot
   logic [DEPTH-1:0]  slot_live;
   logic [DEPTH-1:0]  hit1, hit2;

   // Ready depends only on occupancy: two free slots absorb a dual issue
   assign in_ready   = (DEPTH_C - count_reg) >= CNT_W'(2);
   assign fifo_empty = (count_reg == '0);

   // Writes to x0 are accepted but discarded
   assign ld_take  = bus.ld_valid  & in_ready & (bus.ld_rd  != 5'd0);
   assign alu_take = bus.alu_valid & in_ready & (bus.alu_rd != 5'd0);
   assign ld_fmt   = ld_format(bus.ld_data, bus.ld_size, bus.ld_unsigned);

   // Order the new entries: the load is older than a same-cycle ALU result
   always_comb begin
      new0_valid = ld_take | alu_take;
      new0_rd    = bus.alu_rd;
      new0_data  = bus.alu_data;
      if (ld_take) begin
         new0_rd   = bus.ld_rd;
         new0_data = ld_fmt;
      end
      new1_valid = ld_take & alu_take;
      new1_rd    = bus.alu_rd;
      new1_data  = bus.alu_data;
   end

   // Pick what commits this edge and what goes into the FIFO
   always_comb begin
      deq          = 1'b0;
      commit_valid = 1'b0;
      commit_rd    = rd_mem[rd_ptr_reg];
      commit_data  = data_mem[rd_ptr_reg];
      enq0_valid   = 1'b0;
      enq0_rd      = new0_rd;
      enq0_data    = new0_data;
      enq1_valid   = 1'b0;
      enq1_rd      = new1_rd;
      enq1_data    = new1_data;
      if (!fifo_empty) begin
         // Oldest stored entry commits; all new entries queue behind it
         deq          = 1'b1;
         commit_valid = 1'b1;
         enq0_valid   = new0_valid;
         enq1_valid   = new1_valid;
      end else if (new0_valid) begin
         // Bypass: oldest new entry commits now, a second one is stored
         commit_valid = 1'b1;
         commit_rd    = new0_rd;
         commit_data  = new0_data;
         enq0_valid   = new1_valid;
         enq0_rd      = new1_rd;
         enq0_data    = new1_data;
      end
   end

   // Next pointer and occupancy values; pointers wrap modulo DEPTH
   always_comb begin
      wr_ptr_p1   = wr_ptr_reg + PTR_W'(1);
      wr_ptr_next = wr_ptr_reg + PTR_W'(enq0_valid) + PTR_W'(enq1_valid);
      rd_ptr_next = rd_ptr_reg + PTR_W'(deq);
      count_next  = count_reg + CNT_W'(enq0_valid) + CNT_W'(enq1_valid)
                    - CNT_W'(deq);
   end

   // Pointer and occupancy state; reset drops every stored entry at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // FIFO payload storage; validity is carried by pointers and count
   always_ff @(posedge clk) begin
      if (enq0_valid) begin
         rd_mem[wr_ptr_reg]   <= enq0_rd;
         data_mem[wr_ptr_reg] <= enq0_data;
      end
      if (enq1_valid) begin
         rd_mem[wr_ptr_p1]   <= enq1_rd;
         data_mem[wr_ptr_p1] <= enq1_data;
      end
   end

   // Register-file write port, held stable from posedge to negedge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regwr_reg      <= 1'b0;
         wr_reg_reg     <= '0;
         write_data_reg <= '0;
      end else begin
         regwr_reg <= commit_valid;
         if (commit_valid) begin
            wr_reg_reg     <= {1'b0, commit_rd};
            write_data_reg <= commit_data;
         end
      end
   end

   // A slot is live when its distance from the read pointer is below count
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] offset;
      assign offset        = PTR_W'(gi) - rd_ptr_reg;
      assign slot_live[gi] = ({1'b0, offset} < count_reg);
      assign hit1[gi]      = slot_live[gi] & (rd_mem[gi] == bus.q_rs1);
      assign hit2[gi]      = slot_live[gi] & (rd_mem[gi] == bus.q_rs2);
   end

   // The output-register entry is written at negedge, so it is not pending
   assign bus.pend1      = (|hit1) & (bus.q_rs1 != 5'd0);
   assign bus.pend2      = (|hit2) & (bus.q_rs2 != 5'd0);
   assign bus.in_ready   = in_ready;
   assign bus.regwr      = regwr_reg;
   assign bus.wr_reg     = wr_reg_reg;
   assign bus.write_data = write_data_reg;
endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: a scoreboard queue holds expected commits in
// program order; each cycle the head is compared against the write port.
module tb_wb_commit;
   localparam int DW    = 64;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  rd;
      logic [63:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_commit_if #(.DATA_W(DW)) bus ();

   wb_commit #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t        sbq[$];
   int          total = 0;
   int          bad   = 0;
   logic [4:0]  last_rd   = '0;
   logic [63:0] last_data = '0;
   logic        acc;
   bit          saw_low;
   int          k;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit model_pend(input logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      foreach (sbq[i]) if (sbq[i].rd == r) return 1'b1;
      return 1'b0;
   endfunction

   // One cycle: drive inputs, predict acceptance, clock, check the commit
   task automatic step(input logic lv, input logic [4:0] lrd, input logic [63:0] ldat,
                       input logic [1:0] lsz, input logic lu, input logic [63:0] lexp,
                       input logic av, input logic [4:0] ard, input logic [63:0] adat,
                       output logic accepted);
      bit   rdy;
      exp_t e;
      bus.ld_valid    = lv;
      bus.ld_rd       = lrd;
      bus.ld_data     = ldat;
      bus.ld_size     = lsz;
      bus.ld_unsigned = lu;
      bus.alu_valid   = av;
      bus.alu_rd      = ard;
      bus.alu_data    = adat;
      #1;
      rdy = (DEPTH - sbq.size()) >= 2;
      chk("in_ready", bus.in_ready, rdy);
      accepted = rdy;
      if (rdy && lv && lrd != 5'd0) begin
         e.rd = lrd; e.data = lexp; sbq.push_back(e);
      end
      if (rdy && av && ard != 5'd0) begin
         e.rd = ard; e.data = adat; sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("regwr", bus.regwr, 1'b1);
         chk("wr_reg", bus.wr_reg, {1'b0, e.rd});
         chk("write_data", bus.write_data, e.data);
         last_rd   = e.rd;
         last_data = e.data;
      end else begin
         chk("regwr_idle", bus.regwr, 1'b0);
         chk("wr_reg_hold", bus.wr_reg, {1'b0, last_rd});
         chk("write_data_hold", bus.write_data, last_data);
      end
      chk("pend1", bus.pend1, model_pend(bus.q_rs1));
      chk("pend2", bus.pend2, model_pend(bus.q_rs2));
      $display("t=%0t ld=%b/r%0d alu=%b/r%0d acc=%b regwr=%b wr_reg=%0d data=%h pend=%b%b",
               $time, lv, lrd, av, ard, accepted, bus.regwr, bus.wr_reg,
               bus.write_data, bus.pend1, bus.pend2);
   endtask

   task automatic idle();
      logic a;
      step(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 64'd0, 1'b0, 5'd0, 64'd0, a);
   endtask

   initial begin
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.ld_valid = 1'b0;  bus.ld_rd = '0;  bus.ld_data = '0;
      bus.ld_size = '0;     bus.ld_unsigned = 1'b0;
      bus.q_rs1 = 5'd5;     bus.q_rs2 = 5'd4;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_regwr", bus.regwr, 1'b0);
      chk("rst_wr_reg", bus.wr_reg, 6'd0);
      chk("rst_write_data", bus.write_data, 64'd0);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_pend1", bus.pend1, 1'b0);
      chk("rst_pend2", bus.pend2, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_regwr", bus.regwr, 1'b0);

      // Single ALU write, then idle
      step(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 64'd0, 1'b1, 5'd5, 64'h1234, acc);
      idle();

      // Simultaneous load (older) and ALU result; pend2 watches r4
      bus.q_rs2 = 5'd4;
      step(1'b1, 5'd3, 64'h80, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FF80,
           1'b1, 5'd4, 64'h7, acc);
      chk("pend2_first_commit", bus.pend2, 1'b1);
      idle();
      chk("pend2_after", bus.pend2, 1'b0);

      // x0 write is dropped
      bus.q_rs1 = 5'd0;
      step(1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 64'd0, 1'b1, 5'd0, 64'hDEAD, acc);
      chk("x0_pend1", bus.pend1, 1'b0);
      idle();

      // Load formats
      step(1'b1, 5'd10, 64'hFEDC_BA98_8765_8321, 2'b01, 1'b1, 64'h8321,
           1'b0, 5'd0, 64'd0, acc);
      step(1'b1, 5'd11, 64'hFEDC_BA98_8765_8321, 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_8321,
           1'b0, 5'd0, 64'd0, acc);
      step(1'b1, 5'd12, 64'hFEDC_BA98_8765_8321, 2'b10, 1'b0, 64'hFFFF_FFFF_8765_8321,
           1'b0, 5'd0, 64'd0, acc);
      step(1'b1, 5'd13, 64'hFEDC_BA98_8765_8321, 2'b11, 1'b0, 64'hFEDC_BA98_8765_8321,
           1'b0, 5'd0, 64'd0, acc);

      // Backpressure and pointer wrap: dual issue every cycle, held while not ready
      bus.q_rs1 = 5'd5;
      bus.q_rs2 = 5'd8;
      k = 0;
      saw_low = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step(1'b1, 5'(2*k+1), 64'hA000_0000_0000_0000 | 64'(k), 2'b11, 1'b0,
              64'hA000_0000_0000_0000 | 64'(k),
              1'b1, 5'(2*k+2), 64'hB000_0000_0000_0000 | 64'(k), acc);
         if (acc) k++;
         else saw_low = 1'b1;
      end
      chk("in_ready_dropped", 64'(saw_low), 64'd1);
      for (int c = 0; c < 8 && sbq.size() > 0; c++) idle();
      chk("drain_empty", 64'(sbq.size()), 64'd0);
      idle();

      // Reset with three entries queued
      bus.q_rs1 = 5'd25;
      for (int c = 0; c < 3; c++) begin
         step(1'b1, 5'(23+2*c), 64'hC000 + 64'(c), 2'b11, 1'b0, 64'hC000 + 64'(c),
              1'b1, 5'(24+2*c), 64'hD000 + 64'(c), acc);
      end
      chk("queued_three", 64'(sbq.size()), 64'd3);
      bus.ld_valid  = 1'b0;
      bus.alu_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_regwr", bus.regwr, 1'b0);
      chk("midrst_wr_reg", bus.wr_reg, 6'd0);
      chk("midrst_write_data", bus.write_data, 64'd0);
      chk("midrst_in_ready", bus.in_ready, 1'b1);
      chk("midrst_pend1", bus.pend1, 1'b0);
      sbq.delete();
      last_rd   = '0;
      last_data = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after_rst_regwr", bus.regwr, 1'b0);
      repeat (3) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
